// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: line-burst prefetch into the line buffer has strict
// priority; host single-word accesses are slotted in between bursts.
module vram_scan_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int LINE_WORDS = 320,
    parameter int LB_AW      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              line_done,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {IDLE, SCAN, SCAN_DRAIN, H_ISSUE, H_WAIT} state_t;

    localparam logic [LB_AW-1:0]  LAST_WORD = LB_AW'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] line_base;
    logic              scan_pending;
    logic [LB_AW-1:0]  word_cnt;
    logic [LB_AW-1:0]  idx_d1;
    // [0]: word issued last cycle (rdata valid now); [1]: line-buffer write this cycle
    logic [1:0]        vld_pipe;
    logic              drain_done;

    assign lb_we      = vld_pipe[1];
    assign busy       = (state != IDLE);
    assign drain_done = (state == SCAN_DRAIN) && vld_pipe[1] && !vld_pipe[0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                // host_req is ignored in the ack cycle so one request yields one access
                if (scan_pending || line_start)  state_nxt = SCAN;
                else if (host_req && !host_ack)  state_nxt = H_ISSUE;
            end
            SCAN: begin
                mem_addr = line_base + ADDR_W'(word_cnt);
                if (word_cnt == LAST_WORD) state_nxt = SCAN_DRAIN;
            end
            SCAN_DRAIN: begin
                if (drain_done) state_nxt = IDLE;
            end
            H_ISSUE: begin
                mem_addr  = host_addr;
                mem_we    = host_we;
                mem_wdata = host_wdata;
                state_nxt = H_WAIT;
            end
            H_WAIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_base    <= '0;
            scan_pending <= 1'b0;
            word_cnt     <= '0;
            idx_d1       <= '0;
            vld_pipe     <= '0;
            lb_addr      <= '0;
            lb_data      <= '0;
            line_done    <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            overrun      <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[0], state == SCAN};
            idx_d1    <= word_cnt;
            line_done <= drain_done;
            host_ack  <= (state == H_WAIT);

            if (vld_pipe[0]) begin
                lb_addr <= idx_d1;
                lb_data <= mem_rdata;
            end

            if (state == H_WAIT) host_rdata <= mem_rdata;

            if (state == SCAN) word_cnt <= word_cnt + 1'b1;
            else               word_cnt <= '0;

            // a second line_start mid-burst is dropped and flagged, not queued
            if (state_nxt == SCAN && state != SCAN)  scan_pending <= 1'b0;
            else if (line_start && state != SCAN)    scan_pending <= 1'b1;

            if (line_start && state == SCAN) overrun <= 1'b1;

            if (frame_start)     line_base <= fb_base;
            else if (drain_done) line_base <= line_base + LINE_STEP;
        end
    end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter with LINE_WORDS=4 and a behavioural VRAM.
module tb_vram_scan_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fb_base;
    logic        frame_start, line_start;
    logic        host_req, host_we;
    logic [15:0] host_addr;
    logic [11:0] host_wdata;
    logic        host_ack;
    logic [11:0] host_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        lb_we;
    logic [8:0]  lb_addr;
    logic [11:0] lb_data;
    logic        line_done, busy, overrun;

    int n_chk  = 0;
    int n_fail = 0;

    vram_scan_arbiter #(.ADDR_W(16), .DATA_W(12), .LINE_WORDS(L), .LB_AW(9)) dut (
        .clk(clk), .rst_n(rst_n), .fb_base(fb_base), .frame_start(frame_start),
        .line_start(line_start), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we),
        .lb_addr(lb_addr), .lb_data(lb_data), .line_done(line_done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // VRAM model: power-up pattern plus a written-word overlay, 1-cycle read latency
    logic [11:0] wmem   [0:65535];
    bit          wvalid [0:65535];

    function automatic logic [11:0] vram_init(input logic [15:0] a);
        case (a)
            16'h0100: return 12'hAAA;
            16'h0101: return 12'hBBB;
            16'h0102: return 12'hCCC;
            16'h0103: return 12'hDDD;
            default:  return a[11:0] ^ 12'h5A5;
        endcase
    endfunction

    function automatic logic [11:0] exp_rd(input logic [15:0] a);
        return wvalid[a] ? wmem[a] : vram_init(a);
    endfunction

    always @(posedge clk) begin
        mem_rdata <= exp_rd(mem_addr);
        if (mem_we) begin
            wmem[mem_addr]   <= mem_wdata;
            wvalid[mem_addr] <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the first SCAN cycle; ends in the line_done cycle (back in IDLE).
    task automatic run_burst(input logic [15:0] base, input int inject);
        logic [15:0] a;
        for (int i = 0; i <= L + 2; i++) begin
            line_start = (i == inject);
            if (i < L) begin
                a = base + 16'(i);
                chk("scan_addr", mem_addr, a);
            end
            chk("scan_mem_we", mem_we, 0);
            chk("lb_we", lb_we, (i >= 2 && i < L + 2));
            if (i >= 2 && i < L + 2) begin
                a = base + 16'(i - 2);
                chk("lb_addr", lb_addr, i - 2);
                chk("lb_data", lb_data, exp_rd(a));
            end
            chk("line_done", line_done, (i == L + 2));
            chk("scan_busy", busy, (i < L + 2));
            if (i < L + 2) tick();
        end
        line_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},    host_ack, 0);
        chk({tag, "_rdata"},  host_rdata, 0);
        chk({tag, "_maddr"},  mem_addr, 0);
        chk({tag, "_mwe"},    mem_we, 0);
        chk({tag, "_mwdata"}, mem_wdata, 0);
        chk({tag, "_lbwe"},   lb_we, 0);
        chk({tag, "_lbaddr"}, lb_addr, 0);
        chk({tag, "_lbdata"}, lb_data, 0);
        chk({tag, "_done"},   line_done, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_ovr"},    overrun, 0);
    endtask

    initial begin
        rst_n = 1'b0; fb_base = '0; frame_start = 1'b0; line_start = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: first line after frame_start at 0x0100
        fb_base = 16'h0100; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; line_start = 1'b1;
        tick();
        run_burst(16'h0100, -1);

        // 2: following lines advance by LINE_WORDS, then wrap at the top of VRAM
        for (int k = 1; k <= 3; k++) begin
            repeat (14) tick();
            line_start = 1'b1;
            tick();
            run_burst(16'h0100 + 16'(4 * k), -1);
        end
        repeat (5) tick();
        fb_base = 16'hFFFE; frame_start = 1'b1; line_start = 1'b1;
        tick();
        frame_start = 1'b0;
        run_burst(16'hFFFE, -1);
        tick();

        // 3: host write then host read back
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0200; host_wdata = 12'h055;
        tick();
        chk("hw_issue_we", mem_we, 1);
        chk("hw_issue_addr", mem_addr, 16'h0200);
        chk("hw_issue_wdata", mem_wdata, 12'h055);
        chk("hw_ack_early", host_ack, 0);
        tick();
        chk("hw_wait_we", mem_we, 0);
        tick();
        chk("hw_ack", host_ack, 1);
        host_req = 1'b0; host_we = 1'b0; host_wdata = '0;
        tick();
        chk("hw_ack_pulse", host_ack, 0);
        host_req = 1'b1;
        tick();
        chk("hr_issue_we", mem_we, 0);
        chk("hr_issue_addr", mem_addr, 16'h0200);
        tick();
        tick();
        chk("hr_ack", host_ack, 1);
        chk("hr_rdata", host_rdata, 12'h055);
        tick();
        // req still high during ack: no back-to-back grant from the ack cycle
        chk("hr_no_regrant", busy, 0);
        chk("hr_ack_pulse", host_ack, 0);
        host_req = 1'b0;
        tick();

        // 4: simultaneous host_req and line_start, burst first (line_base now 0x0002)
        host_req = 1'b1; host_addr = 16'h0104; line_start = 1'b1;
        tick();
        run_burst(16'h0002, -1);
        chk("t4_ack_late", host_ack, 0);
        tick();
        chk("t4_grant_addr", mem_addr, 16'h0104);
        chk("t4_grant_busy", busy, 1);
        tick();
        tick();
        chk("t4_ack", host_ack, 1);
        chk("t4_rdata", host_rdata, vram_init(16'h0104));
        host_req = 1'b0;
        tick();

        // 5: line_start mid-burst sets sticky overrun, no extra burst
        line_start = 1'b1;
        tick();
        run_burst(16'h0006, 2);
        chk("ovr_set", overrun, 1);
        repeat (6) tick();
        chk("ovr_no_burst", busy, 0);
        chk("ovr_no_lbwe", lb_we, 0);
        chk("ovr_sticky", overrun, 1);

        // 6: reset at burst word 2
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("rst_w0_addr", mem_addr, 16'h000A);
        tick();
        tick();
        chk("rst_w2_addr", mem_addr, 16'h000C);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("post_rst_done", line_done, 0);
            chk("post_rst_lbwe", lb_we, 0);
        end
        line_start = 1'b1;
        tick();
        run_burst(16'h0000, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
